mux_src_arb: RTL and testbench

Two-source round-robin arbiter with a registered output stage, placed directly upstream of the parameterised 2:1 `mux`. It accepts data from sources A and B over valid/ready handshakes and picks one per transfer. It registers the chosen word together with the `SEL` value that drives the downstream `mux` select. `SEL` is always a registered, reset-defined 0/1 and is never X.

---
 rtl/mux_src_arb.sv | 97 +++++++++
 tb/tb_mux_src_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_src_arb.sv
// mux_src_arb
// Two-source round-robin arbiter with a registered output stage. It feeds the
// select and data of a downstream 2:1 mux, so SEL and OUT_DATA always update
// on the same edge.
//
// Ports
//   CLK, RST_N           clock, asynchronous active-low reset
//   A_VALID/A_DATA/A_READY  source A handshake
//   B_VALID/B_DATA/B_READY  source B handshake
//   OUT_VALID/OUT_DATA/OUT_READY  registered output handshake
//   SEL                  registered grant index (0 = A, 1 = B)
//   GNT_CNT_A/GNT_CNT_B  wrapping per-source grant counters
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | output register holds no word (OUT_VALID = 0)
// FULL  | output register holds a word  (OUT_VALID = 1)

module mux_src_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A_VALID,
    input  logic [WIDTH-1:0] A_DATA,
    output logic             A_READY,
    input  logic             B_VALID,
    input  logic [WIDTH-1:0] B_DATA,
    output logic             B_READY,
    output logic             OUT_VALID,
    output logic [WIDTH-1:0] OUT_DATA,
    input  logic             OUT_READY,
    output logic             SEL,
    output logic [CNT_W-1:0] GNT_CNT_A,
    output logic [CNT_W-1:0] GNT_CNT_B
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic               last;
    logic [WIDTH-1:0]   out_data_q;
    logic               sel_q;
    logic [CNT_W-1:0]   cnt_a_q;
    logic [CNT_W-1:0]   cnt_b_q;

    logic               load;
    logic               any_gnt;
    logic               gnt_b;

    // On a tie the source opposite to LAST wins; LAST resets to 1 so A wins first.
    always_comb begin
        load    = (state == EMPTY) | OUT_READY;
        any_gnt = A_VALID | B_VALID;
        gnt_b   = B_VALID & (~A_VALID | ~last);
    end

    // Gated by RST_N so neither source sees a handshake while reset is held.
    assign A_READY   = RST_N & load & A_VALID & ~gnt_b;
    assign B_READY   = RST_N & load & gnt_b;

    assign OUT_VALID = (state == FULL);
    assign OUT_DATA  = out_data_q;
    assign SEL       = sel_q;
    assign GNT_CNT_A = cnt_a_q;
    assign GNT_CNT_B = cnt_b_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= EMPTY;
            last       <= 1'b1;
            out_data_q <= '0;
            sel_q      <= 1'b0;
            cnt_a_q    <= '0;
            cnt_b_q    <= '0;
        end else if (load) begin
            if (any_gnt) begin
                state      <= FULL;
                out_data_q <= gnt_b ? B_DATA : A_DATA;
                sel_q      <= gnt_b;
                last       <= gnt_b;
                if (gnt_b)
                    cnt_b_q <= cnt_b_q + CNT_W'(1);
                else
                    cnt_a_q <= cnt_a_q + CNT_W'(1);
            end else begin
                // Drain: data, select and LAST keep their last values.
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_mux_src_arb.sv
// tb_mux_src_arb
// Directed testbench for mux_src_arb (WIDTH=4, CNT_W=8). Inputs are driven
// 1 time unit after the rising edge; outputs are sampled there as well.

module tb_mux_src_arb;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [3:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [3:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       sel;
    logic [7:0] gnt_cnt_a;
    logic [7:0] gnt_cnt_b;

    int vectors;
    int miscompares;

    logic [7:0] exp_a;
    logic [7:0] exp_b;

    mux_src_arb #(.WIDTH(4), .CNT_W(8)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .A_VALID   (a_valid),
        .A_DATA    (a_data),
        .A_READY   (a_ready),
        .B_VALID   (b_valid),
        .B_DATA    (b_data),
        .B_READY   (b_ready),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_READY (out_ready),
        .SEL       (sel),
        .GNT_CNT_A (gnt_cnt_a),
        .GNT_CNT_B (gnt_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        a_data    = 4'b0110;
        b_valid   = 1'b1;
        b_data    = 4'b1001;
        out_ready = 1'b1;
        #3;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++;
        if (out_data !== 4'b0000) begin miscompares++; $display("FAIL reset_data: got %b expected 0000", out_data); end
        vectors++;
        if (sel !== 1'b0) begin miscompares++; $display("FAIL reset_sel: got %b expected 0", sel); end
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
        vectors++;
        if (gnt_cnt_a !== 8'd0 || gnt_cnt_b !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got a=%0d b=%0d expected 0 0", gnt_cnt_a, gnt_cnt_b); end
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_a = 8'd0;
        exp_b = 8'd0;
    endtask

    task automatic test_single();
        a_valid   = 1'b1;
        a_data    = 4'b1010;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin miscompares++; $display("FAIL single_ready: got a=%b b=%b expected 1 0", a_ready, b_ready); end
        step();
        exp_a = exp_a + 8'd1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010 || sel !== 1'b0) begin
            miscompares++; $display("FAIL single_out: got v=%b d=%b s=%b expected 1 1010 0", out_valid, out_data, sel);
        end
        vectors++;
        if (gnt_cnt_a !== exp_a || gnt_cnt_b !== exp_b) begin miscompares++; $display("FAIL single_cnt: got a=%0d b=%0d expected %0d %0d", gnt_cnt_a, gnt_cnt_b, exp_a, exp_b); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_sel;
        logic [15:0] exp_dat;
        // LAST is A after test_single; a lone B grant sets LAST=B so the tie run starts with A.
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 4'b1111;
        step();
        exp_b = exp_b + 8'd1;
        vectors++;
        if (sel !== 1'b1 || out_data !== 4'b1111) begin miscompares++; $display("FAIL rr_setup: got s=%b d=%b expected 1 1111", sel, out_data); end
        a_valid = 1'b1;
        a_data  = 4'b0000;
        exp_sel = 4'b1010;            // bit i = expected SEL on cycle i
        exp_dat = 16'hF0F0;           // nibble i = expected OUT_DATA on cycle i
        for (int i = 0; i < 4; i++) begin
            step();
            if (exp_sel[i]) exp_b = exp_b + 8'd1; else exp_a = exp_a + 8'd1;
            vectors++;
            if (out_valid !== 1'b1 || sel !== exp_sel[i] || out_data !== exp_dat[i*4 +: 4]) begin
                miscompares++;
                $display("FAIL rr_cycle%0d: got v=%b s=%b d=%b expected 1 %b %b", i, out_valid, sel, out_data, exp_sel[i], exp_dat[i*4 +: 4]);
            end
        end
        vectors++;
        if (gnt_cnt_a !== exp_a || gnt_cnt_b !== exp_b) begin miscompares++; $display("FAIL rr_cnt: got a=%0d b=%0d expected %0d %0d", gnt_cnt_a, gnt_cnt_b, exp_a, exp_b); end
    endtask

    task automatic test_backpressure();
        // Entry: FULL, SEL=1, OUT_DATA=1111, LAST=B.
        out_ready = 1'b0;
        a_valid   = 1'b1;
        a_data    = 4'b0101;
        b_valid   = 1'b1;
        b_data    = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready%0d: got a=%b b=%b expected 0 0", i, a_ready, b_ready); end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 4'b1111 || sel !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold%0d: got v=%b d=%b s=%b expected 1 1111 1", i, out_valid, out_data, sel);
            end
            vectors++;
            if (gnt_cnt_a !== exp_a || gnt_cnt_b !== exp_b) begin miscompares++; $display("FAIL bp_cnt%0d: got a=%0d b=%0d expected %0d %0d", i, gnt_cnt_a, gnt_cnt_b, exp_a, exp_b); end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin miscompares++; $display("FAIL bp_release_ready: got a=%b b=%b expected 1 0", a_ready, b_ready); end
        step();
        exp_a = exp_a + 8'd1;
        vectors++;
        if (out_valid !== 1'b1 || sel !== 1'b0 || out_data !== 4'b0101) begin
            miscompares++; $display("FAIL bp_release_out: got v=%b s=%b d=%b expected 1 0 0101", out_valid, sel, out_data);
        end
    endtask

    task automatic test_drain();
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miscompares++; $display("FAIL drain_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 4'b0101 || sel !== 1'b0) begin
            miscompares++; $display("FAIL drain_out: got v=%b d=%b s=%b expected 0 0101 0", out_valid, out_data, sel);
        end
        // EMPTY loads regardless of OUT_READY; LAST=A so a lone B wins.
        out_ready = 1'b0;
        b_valid   = 1'b1;
        b_data    = 4'b1100;
        #1;
        vectors++;
        if (b_ready !== 1'b1 || a_ready !== 1'b0) begin miscompares++; $display("FAIL empty_load_ready: got a=%b b=%b expected 0 1", a_ready, b_ready); end
        step();
        exp_b = exp_b + 8'd1;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 4'b1100 || sel !== 1'b1) begin
            miscompares++; $display("FAIL empty_load_out: got v=%b d=%b s=%b expected 1 1100 1", out_valid, out_data, sel);
        end
    endtask

    task automatic test_counter_wrap();
        int wraps;
        wraps     = 0;
        out_ready = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b1;
        b_data    = 4'b0111;
        for (int i = 0; i < 256; i++) begin
            step();
            if (exp_b == 8'd255) wraps++;
            exp_b = exp_b + 8'd1;
            vectors++;
            if (gnt_cnt_b !== exp_b || gnt_cnt_a !== exp_a) begin
                miscompares++; $display("FAIL wrap_step%0d: got a=%0d b=%0d expected %0d %0d", i, gnt_cnt_a, gnt_cnt_b, exp_a, exp_b);
            end
        end
        vectors++;
        if (wraps != 1) begin miscompares++; $display("FAIL wrap_seen: got %0d wraps expected 1", wraps); end
    endtask

    task automatic test_reset_mid();
        b_valid   = 1'b0;
        a_valid   = 1'b1;
        a_data    = 4'b1111;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 4'b1111) begin miscompares++; $display("FAIL rstmid_pre: got v=%b d=%b expected 1 1111", out_valid, out_data); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || sel !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_out: got v=%b d=%b s=%b expected 0 0000 0", out_valid, out_data, sel);
        end
        vectors++;
        if (gnt_cnt_a !== 8'd0 || gnt_cnt_b !== 8'd0) begin miscompares++; $display("FAIL rstmid_cnt: got a=%0d b=%0d expected 0 0", gnt_cnt_a, gnt_cnt_b); end
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_ready: got a=%b b=%b expected 0 0", a_ready, b_ready); end
        // Tie right after reset must go to A since LAST resets to B.
        a_valid = 1'b1;
        a_data  = 4'b0001;
        b_valid = 1'b1;
        b_data  = 4'b0010;
        step();
        rst_n = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b1 || sel !== 1'b0 || out_data !== 4'b0001 || gnt_cnt_a !== 8'd1) begin
            miscompares++; $display("FAIL rstmid_first_tie: got v=%b s=%b d=%b ca=%0d expected 1 0 0001 1", out_valid, sel, out_data, gnt_cnt_a);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_counter_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
